core_ctrl: RTL and testbench

Instruction sequencer directly upstream of `core`. It generates the 34-bit `inst` word that drives `core` for one weight/activation tile:
- fetch weights from xmem into L0, then load them into the MAC array;
- fetch activations into L0 and execute;
- drain the output FIFO into psum memory.

It uses one FSM with registered outputs, and `ofifo_valid` from `core` is its only feedback.

---
 rtl/core_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: tile sequencer that produces the 34-bit inst word for core.
// A single FSM decodes the next state; every output is registered from that decode.
module core_ctrl #(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int len_nij   = 36,
    parameter int drain_max = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] cfg_w_base,
    input  logic [10:0] cfg_x_base,
    input  logic [10:0] cfg_p_base,
    input  logic        cfg_acc,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;
    localparam int CNT_W = 16;
    localparam int IDX_W = 12;

    localparam int B_ACC   = 33;
    localparam int B_CENP  = 32;
    localparam int B_WENP  = 31;
    localparam int AP_HI   = 30;
    localparam int AP_LO   = 20;
    localparam int B_CENX  = 19;
    localparam int AX_HI   = 17;
    localparam int AX_LO   = 7;
    localparam int B_OFRD  = 6;
    localparam int B_L0RD  = 3;
    localparam int B_L0WR  = 2;
    localparam int B_EXEC  = 1;
    localparam int B_LOAD  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_LOAD,
        S_W_SETTLE,
        S_X_FETCH,
        S_EXEC,
        S_DRAIN,
        S_READOUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] rd_q, rd_d;
    logic [IDX_W-1:0] wr_q, wr_d;
    logic [10:0]      w_base_q, w_base_d;
    logic [10:0]      x_base_q, x_base_d;
    logic [10:0]      p_base_q, p_base_d;
    logic             acc_q, acc_d;
    logic [33:0]      inst_q, inst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rd_en, wr_en;
    logic [10:0]      fetch_base;
    logic [CNT_W-1:0] fetch_len;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q + CNT_W'(1);
        rd_d     = rd_q;
        wr_d     = wr_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        p_base_d = p_base_q;
        acc_d    = acc_q;
        err_d    = err_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (start) begin
                    state_d  = S_W_FETCH;
                    w_base_d = cfg_w_base;
                    x_base_d = cfg_x_base;
                    p_base_d = cfg_p_base;
                    acc_d    = cfg_acc;
                    err_d    = 1'b0;
                end
            end
            S_W_FETCH: begin
                if (k_q == CNT_W'(col)) begin
                    state_d = S_W_LOAD;
                    k_d     = '0;
                end
            end
            S_W_LOAD: begin
                if (k_q == CNT_W'(col - 1)) begin
                    state_d = S_W_SETTLE;
                    k_d     = '0;
                end
            end
            S_W_SETTLE: begin
                if (k_q == CNT_W'(row - 1)) begin
                    state_d = S_X_FETCH;
                    k_d     = '0;
                end
            end
            S_X_FETCH: begin
                if (k_q == CNT_W'(len_nij)) begin
                    state_d = S_EXEC;
                    k_d     = '0;
                end
            end
            S_EXEC: begin
                // Readout counters are cleared here so DRAIN can hand over a clean slate.
                if (k_q == CNT_W'(len_nij - 1)) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    state_d = S_READOUT;
                    k_d     = '0;
                end else if (k_q == CNT_W'(drain_max - 1)) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    err_d   = 1'b1;
                end
            end
            S_READOUT: begin
                k_d = '0;
                if (wr_q == IDX_W'(len_nij)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase

        // A read seen in this cycle becomes a pmem write in the next one.
        rd_en = (state_d == S_READOUT) && ofifo_valid && (rd_q < IDX_W'(len_nij));
        wr_en = (state_q == S_READOUT) && inst_q[B_OFRD];
        if (rd_en) rd_d = rd_q + IDX_W'(1);
        if (wr_en) wr_d = wr_q + IDX_W'(1);

        busy_d     = (state_d != S_IDLE);
        fetch_base = (state_d == S_W_FETCH) ? w_base_d : x_base_d;
        fetch_len  = (state_d == S_W_FETCH) ? CNT_W'(col) : CNT_W'(len_nij);

        inst_d = IDLE_WORD;
        unique case (state_d)
            S_W_FETCH, S_X_FETCH: begin
                if (k_d < fetch_len) begin
                    inst_d[B_CENX]      = 1'b0;
                    inst_d[AX_HI:AX_LO] = fetch_base + k_d[10:0];
                end
                inst_d[B_L0WR] = (k_d != '0);
            end
            S_W_LOAD: begin
                inst_d[B_L0RD] = 1'b1;
                inst_d[B_LOAD] = 1'b1;
            end
            S_EXEC: begin
                inst_d[B_ACC]  = acc_d;
                inst_d[B_L0RD] = 1'b1;
                inst_d[B_EXEC] = 1'b1;
            end
            S_DRAIN: begin
                inst_d[B_ACC]  = acc_d;
                inst_d[B_EXEC] = 1'b1;
            end
            S_READOUT: begin
                inst_d[B_OFRD] = rd_en;
                if (wr_en) begin
                    inst_d[B_CENP]      = 1'b0;
                    inst_d[B_WENP]      = 1'b0;
                    inst_d[AP_HI:AP_LO] = p_base_d + wr_q[10:0];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Tile configuration is only consulted outside IDLE, after a start has loaded it.
    always_ff @(posedge clk) begin
        w_base_q <= w_base_d;
        x_base_q <= x_base_d;
        p_base_q <= p_base_d;
        acc_q    <= acc_d;
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: a cycle-level reference built from the tile timeline
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_core_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int NIJ  = 36;
    localparam int DMAX = 64;
    localparam logic [33:0] IDLE_W = 34'h1800C0000;
    localparam int FIX_LEN  = (COL + 1) + COL + ROW + (NIJ + 1) + NIJ;
    localparam int TILE_LEN = FIX_LEN + 1 + (NIJ + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] cfg_w_base = '0;
    logic [10:0] cfg_x_base = '0;
    logic [10:0] cfg_p_base = '0;
    logic        cfg_acc = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic        busy, done, err;

    core_ctrl #(.row(ROW), .col(COL), .len_nij(NIJ), .drain_max(DMAX)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_p_base(cfg_p_base),
        .cfg_acc(cfg_acc), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tiles    = 0;
    int vmode    = 0;
    int vcyc     = 0;
    logic [33:0] trace [0:399];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: describes the upcoming cycle after each rising edge.
    int          m_phase, m_t, m_d, m_reads, m_writes;
    bit          m_pend;
    logic [10:0] m_w, m_x, m_p;
    logic        m_acc;
    logic [33:0] exp_inst;
    logic        exp_busy, exp_done, exp_err;

    function automatic logic [33:0] mk(input logic acc, cenp, wenp, input logic [10:0] ap,
                                       input logic cenx, wenx, input logic [10:0] ax,
                                       input logic ofrd, l0rd, l0wr, exe, ld);
        return {acc, cenp, wenp, ap, cenx, wenx, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
    endfunction

    function automatic logic [33:0] fetch_word(input int k, input logic [10:0] base, input int n);
        logic rd_on;
        rd_on = (k < n);
        return mk(1'b0, 1'b1, 1'b1, 11'd0, !rd_on, 1'b1, rd_on ? base + 11'(k) : 11'd0,
                  1'b0, 1'b0, (k >= 1), 1'b0, 1'b0);
    endfunction

    function automatic logic [33:0] fixed_word(input int t);
        int b1, b2, b3, b4;
        b1 = COL + 1;
        b2 = b1 + COL;
        b3 = b2 + ROW;
        b4 = b3 + NIJ + 1;
        if (t < b1) return fetch_word(t, m_w, COL);
        if (t < b2) return mk(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        if (t < b3) return IDLE_W;
        if (t < b4) return fetch_word(t - b3, m_x, NIJ);
        return mk(m_acc, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic model_step();
        bit wr, ofrd;
        int widx;
        wr = 1'b0;
        ofrd = 1'b0;
        widx = 0;
        exp_done = 1'b0;
        case (m_phase)
            0: if (start) begin
                m_w = cfg_w_base; m_x = cfg_x_base; m_p = cfg_p_base; m_acc = cfg_acc;
                exp_err = 1'b0; m_phase = 1; m_t = 0;
            end
            1: begin
                m_t++;
                if (m_t == FIX_LEN) begin m_phase = 2; m_d = 0; end
            end
            2: if (ofifo_valid) begin
                m_phase = 3; m_reads = 0; m_writes = 0; m_pend = 1'b0;
            end else if (m_d == DMAX - 1) begin
                m_phase = 0; exp_err = 1'b1;
            end else begin
                m_d++;
            end
            default: if (m_writes == NIJ) begin m_phase = 0; exp_done = 1'b1; end
        endcase
        if (m_phase == 3) begin
            wr = m_pend;
            widx = m_writes;
            if (wr) m_writes++;
            ofrd = ofifo_valid && (m_reads < NIJ);
            if (ofrd) m_reads++;
            m_pend = ofrd;
        end
        case (m_phase)
            0: exp_inst = IDLE_W;
            1: exp_inst = fixed_word(m_t);
            2: exp_inst = mk(m_acc, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            default: exp_inst = mk(1'b0, !wr, !wr, wr ? m_p + 11'(widx) : 11'd0, 1'b1, 1'b1, 11'd0,
                                   ofrd, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
        exp_busy = (m_phase != 0);
    endtask

    initial begin
        m_phase = 0; m_t = 0; m_d = 0; m_reads = 0; m_writes = 0; m_pend = 1'b0;
        m_w = '0; m_x = '0; m_p = '0; m_acc = 1'b0;
        exp_inst = IDLE_W; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_phase = 0; exp_inst = IDLE_W; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_inst", 64'(inst), 64'(IDLE_W));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_err",  64'(err),  64'(0));
        end else begin
            check("inst", 64'(inst), 64'(exp_inst));
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            check("err",  64'(err),  64'(exp_err));
            if (done) tiles++;
        end
    end

    // ofifo_valid driver: 0 = low, 1 = high, otherwise the 1,0,0,1 pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vcyc++;
            case (vmode)
                0: ofifo_valid = 1'b0;
                1: ofifo_valid = 1'b1;
                default: ofifo_valid = ((vcyc % 4) == 0) || ((vcyc % 4) == 3);
            endcase
        end
    end

    task automatic start_tile(input logic [10:0] w, input logic [10:0] x,
                              input logic [10:0] p, input logic acc);
        @(posedge clk);
        #1;
        cfg_w_base = w; cfg_x_base = x; cfg_p_base = p; cfg_acc = acc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic observe(input logic [10:0] pb, output int done_idx, output int err_idx,
                           output int nwr, output int badaddr, output int nload,
                           output int ndrain, output int nacc, output int accbad,
                           output int l0mask, output int err0);
        done_idx = -1; err_idx = -1; nwr = 0; badaddr = 0; nload = 0;
        ndrain = 0; nacc = 0; accbad = 0; l0mask = 0; err0 = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            trace[c] = inst;
            if (c == 0) err0 = int'(err);
            if (inst[0]) nload++;
            if (inst[1] && !inst[3]) ndrain++;
            if (inst[33]) nacc++;
            if (inst[33] && !inst[1]) accbad++;
            if (c < COL + 1 && inst[2]) l0mask |= (1 << c);
            if (!inst[31]) begin
                if (inst[30:20] != pb + 11'(nwr)) badaddr++;
                nwr++;
            end
            if (done) begin done_idx = c; break; end
            if (err && !busy) begin err_idx = c; break; end
        end
    endtask

    int d_idx, e_idx, nwr, bad, nload, ndrain, nacc, accbad, l0mask, err0, t0, ndone;

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_inst_lit", 64'(inst), 64'h1800C0000);
        check("reset_busy_lit", 64'(busy), 64'(0));
        @(negedge clk);
        #2 reset = 1'b1;

        // Full tile, weight base wraps past 7FF.
        @(negedge clk); vmode = 1;
        start_tile(11'h7FE, 11'h010, 11'h100, 1'b0);
        observe(11'h100, d_idx, e_idx, nwr, bad, nload, ndrain, nacc, accbad, l0mask, err0);
        check("full_done_cycle", 64'(d_idx), 64'(136));
        check("full_writes", 64'(nwr), 64'(36));
        check("full_addr_gaps", 64'(bad), 64'(0));
        check("wfetch_word0", 64'(trace[0]), 64'h18007FF00);
        check("wfetch_word1", 64'(trace[1]), 64'h18007FF84);
        check("wfetch_word2", 64'(trace[2]), 64'h180040004);
        check("l0wr_cycles", 64'(l0mask), 64'h1FE);
        check("load_count", 64'(nload), 64'(8));
        check("wload_word", 64'(trace[9]), 64'h1800C0009);
        check("first_pmem_word", 64'(trace[100]), 64'h0100C0040);
        check("acc_off", 64'(nacc), 64'(0));

        // Readout stall with a toggling ofifo_valid; pmem base wraps.
        @(negedge clk); vmode = 2;
        start_tile(11'h020, 11'h040, 11'h7F0, 1'b0);
        observe(11'h7F0, d_idx, e_idx, nwr, bad, nload, ndrain, nacc, accbad, l0mask, err0);
        check("stall_done_seen", 64'(d_idx != -1), 64'(1));
        check("stall_longer", 64'(d_idx > TILE_LEN), 64'(1));
        check("stall_writes", 64'(nwr), 64'(36));
        check("stall_addr_gaps", 64'(bad), 64'(0));

        // Drain timeout.
        @(negedge clk); vmode = 0;
        start_tile(11'h000, 11'h100, 11'h200, 1'b1);
        observe(11'h200, d_idx, e_idx, nwr, bad, nload, ndrain, nacc, accbad, l0mask, err0);
        check("timeout_err_cycle", 64'(e_idx), 64'(FIX_LEN + DMAX));
        check("timeout_drain_cycles", 64'(ndrain), 64'(64));
        check("timeout_no_done", 64'(d_idx), 64'(-1));
        check("timeout_err_sticky", 64'(err), 64'(1));

        // acc and a start pulse while busy; the new start also clears err.
        @(negedge clk); vmode = 1;
        t0 = tiles;
        start_tile(11'h005, 11'h080, 11'h300, 1'b1);
        fork
            observe(11'h300, d_idx, e_idx, nwr, bad, nload, ndrain, nacc, accbad, l0mask, err0);
            begin
                repeat (20) @(posedge clk);
                #1 start = 1'b1; cfg_w_base = 11'h3AA; cfg_acc = 1'b0;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check("err_cleared", 64'(err0), 64'(0));
        check("acc_done_cycle", 64'(d_idx), 64'(136));
        check("acc_cycles", 64'(nacc), 64'(NIJ + 1));
        check("acc_outside_exec", 64'(accbad), 64'(0));
        check("exec_acc_word", 64'(trace[62]), 64'h3800C000A);
        repeat (20) @(negedge clk);
        check("busy_start_ignored", 64'(tiles - t0), 64'(1));
        check("idle_after_tile", 64'(busy), 64'(0));

        // Reset in the middle of EXEC abandons the tile.
        @(negedge clk); vmode = 1;
        start_tile(11'h010, 11'h020, 11'h030, 1'b0);
        repeat (70) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_inst", 64'(inst), 64'h1800C0000);
        check("midreset_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'(0));
        check("midreset_idle", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
